// File: rtl/dense_stream_ctrl.sv
// dense_stream_ctrl: credit-gated launch into a fixed-latency dense layer, tag tracking of
// launched vectors, and a show-ahead result FIFO sized so no result is ever dropped.
module dense_stream_ctrl #(
  parameter int WIDTH       = 17,
  parameter int INPUT_SIZE  = 32,
  parameter int OUTPUT_SIZE = 32,
  parameter int LATENCY     = 6,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic signed [WIDTH-1:0]            in_data [0:INPUT_SIZE-1],
  output logic signed [WIDTH-1:0]            dp_in [0:INPUT_SIZE-1],
  input  logic signed [WIDTH-1:0]            dp_result [0:OUTPUT_SIZE-1],
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic signed [WIDTH-1:0]            out_data [0:OUTPUT_SIZE-1],
  output logic [$clog2(LATENCY+1)-1:0]       in_flight,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               overflow_err
);
  localparam int FW = $clog2(LATENCY+1);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  logic [LATENCY-1:0] tag;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic signed [WIDTH-1:0] mem [FIFO_DEPTH][OUTPUT_SIZE];
  logic acc, pop, cap, full, wr_en;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(FIFO_DEPTH-1) ? '0 : p + PW'(1);
  endfunction
  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign cap = tag[LATENCY-1];
  assign full = fifo_count == CW'(FIFO_DEPTH);
  assign wr_en = cap & ~full;
  assign out_valid = fifo_count != '0;
  // Every launched vector already owns a FIFO slot, so admission never looks at out_ready
  assign in_ready = !reset && (int'(in_flight) + int'(fifo_count) < FIFO_DEPTH);
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < LATENCY; i++) in_flight = in_flight + FW'(tag[i]);
  end
  always_comb begin
    for (int j = 0; j < OUTPUT_SIZE; j++) out_data[j] = out_valid ? mem[rd_ptr][j] : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag          <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      fifo_count   <= '0;
      overflow_err <= 1'b0;
      dp_in        <= '{default: '0};
    end else begin
      tag          <= (tag << 1) | LATENCY'(acc);
      rd_ptr       <= pop ? inc(rd_ptr) : rd_ptr;
      wr_ptr       <= wr_en ? inc(wr_ptr) : wr_ptr;
      fifo_count   <= fifo_count + CW'(wr_en) - CW'(pop);
      overflow_err <= overflow_err | (cap & full);
      if (acc) dp_in <= in_data;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= dp_result;
  end
endmodule

// File: tb/tb_dense_stream_ctrl.sv
// tb_dense_stream_ctrl: scoreboard bench with a LATENCY-delayed "+1" dense-layer model.
module tb_dense_stream_ctrl;
  localparam int W = 17;
  localparam int L = 4;
  localparam int D = 2;
  localparam int N = 2;
  logic clk = 0;
  logic reset = 1;
  logic in_valid = 0;
  logic out_ready = 0;
  logic in_ready, out_valid, overflow_err;
  logic signed [W-1:0] in_data [0:N-1];
  logic signed [W-1:0] dp_in [0:N-1];
  logic signed [W-1:0] dp_result [0:N-1];
  logic signed [W-1:0] out_data [0:N-1];
  logic signed [W-1:0] p1 [0:N-1];
  logic signed [W-1:0] p2 [0:N-1];
  logic signed [W-1:0] p3 [0:N-1];
  logic [2:0] in_flight;
  logic [1:0] fifo_count;
  logic [2*W-1:0] sb [$];
  logic [2*W-1:0] e;
  int checks = 0;
  int failures = 0;

  dense_stream_ctrl #(.WIDTH(W), .INPUT_SIZE(N), .OUTPUT_SIZE(N), .LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dp_in(dp_in), .dp_result(dp_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .in_flight(in_flight), .fifo_count(fifo_count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // Dense layer model: result sampled at edge k+L reflects dp_in written at edge k
  always @(posedge clk) begin
    p1 <= dp_in;
    p2 <= p1;
    p3 <= p2;
  end
  always_comb begin
    for (int j = 0; j < N; j++) dp_result[j] = W'(p3[j % N] + 1);
  end

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL stale_out: got %0d,%0d with no result pending", out_data[0], out_data[1]);
      end else begin
        e = sb.pop_front();
        if ({out_data[0], out_data[1]} !== e) begin
          failures++;
          $display("FAIL order: got %0d,%0d want %0d,%0d", out_data[0], out_data[1],
                   $signed(e[2*W-1:W]), $signed(e[W-1:0]));
        end
      end
    end
    if (in_valid && in_ready) sb.push_back({W'(in_data[0] + 1), W'(in_data[1] + 1)});
  end

  task automatic setv(input int a, input int b);
    in_data[0] = W'(a);
    in_data[1] = W'(b);
  endtask

  task automatic test_reset();
    setv(0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, in_flight, fifo_count, overflow_err} !== 8'b0) begin
      failures++;
      $display("FAIL reset_held: got %b want 00000000", {in_ready, out_valid, in_flight, fifo_count, overflow_err});
    end
    checks++;
    if ({out_data[0], out_data[1], dp_in[0], dp_in[1]} !== '0) begin
      failures++;
      $display("FAIL reset_data: got %0d %0d %0d %0d want 0", out_data[0], out_data[1], dp_in[0], dp_in[1]);
    end
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, in_flight, fifo_count, overflow_err} !== 8'b1000_0000) begin
      failures++;
      $display("FAIL reset_release: got %b want 10000000", {in_ready, out_valid, in_flight, fifo_count, overflow_err});
    end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    setv(5, -3);
    in_valid = 1;
    out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    setv(99, 99);
    @(negedge clk);
    checks++;
    if ({dp_in[0], dp_in[1]} !== {17'sd5, -17'sd3} || in_flight !== 3'd1) begin
      failures++;
      $display("FAIL single_launch: got dp_in %0d,%0d in_flight %0d want 5,-3 and 1", dp_in[0], dp_in[1], in_flight);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (k == 4)) begin
        failures++;
        $display("FAIL single_latency: after edge %0d out_valid %b want %b", k, out_valid, k == 4);
      end
    end
    checks++;
    if ({out_data[0], out_data[1]} !== {17'sd6, -17'sd2}) begin
      failures++;
      $display("FAIL single_data: got %0d,%0d want 6,-2", out_data[0], out_data[1]);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, in_flight, fifo_count} !== 6'b0 || {dp_in[0], dp_in[1]} !== {17'sd5, -17'sd3}) begin
      failures++;
      $display("FAIL single_done: got valid %b in_flight %0d count %0d dp_in %0d,%0d want 0 0 0 5,-3",
               out_valid, in_flight, fifo_count, dp_in[0], dp_in[1]);
    end
  endtask

  task automatic test_stream();
    int idx = 0;
    for (int c = 0; c < 300 && idx < 10; c++) begin
      @(posedge clk); #1;
      out_ready = 1;
      in_valid = 1;
      setv(idx * 7 - 20, 50 - idx * 11);
      @(negedge clk);
      checks++;
      if (in_ready !== (int'(in_flight) + int'(fifo_count) < D)) begin
        failures++;
        $display("FAIL stream_credit: in_ready %b with in_flight %0d count %0d", in_ready, in_flight, fifo_count);
      end
      if (in_ready) idx++;
    end
    @(posedge clk); #1;
    in_valid = 0;
    for (int c = 0; c < 50 && sb.size() != 0; c++) @(negedge clk);
    checks++;
    if (sb.size() != 0 || idx != 10 || overflow_err !== 1'b0) begin
      failures++;
      $display("FAIL stream_done: got sent %0d pending %0d overflow %b want 10 0 0", idx, sb.size(), overflow_err);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      out_ready = 0;
      in_valid = 1;
      setv(100 + n, -100 - n);
      @(negedge clk);
      if (in_ready) n++;
    end
    checks++;
    if (n != 2 || in_ready !== 1'b0 || fifo_count !== 2'd2) begin
      failures++;
      $display("FAIL bp_accept: got accepted %0d in_ready %b count %0d want 2 0 2", n, in_ready, fifo_count);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({out_data[0], out_data[1]} !== {17'sd101, -17'sd99}) begin
      failures++;
      $display("FAIL bp_hold: got %0d,%0d want 101,-99", out_data[0], out_data[1]);
    end
    for (int c = 0; c < 100 && n < 5; c++) begin
      @(posedge clk); #1;
      out_ready = 1;
      setv(100 + n, -100 - n);
      @(negedge clk);
      if (in_ready) n++;
    end
    @(posedge clk); #1;
    in_valid = 0;
    for (int c = 0; c < 50 && sb.size() != 0; c++) @(negedge clk);
    checks++;
    if (n != 5 || sb.size() != 0) begin
      failures++;
      $display("FAIL bp_drain: got accepted %0d pending %0d want 5 0", n, sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_pop_capture();
    int n = 0;
    int ev = 0;
    logic pp = 0;
    logic [1:0] fc = 0;
    for (int c = 0; c < 200 && (n < 6 || sb.size() != 0); c++) begin
      @(posedge clk); #1;
      out_ready = 1;
      in_valid = n < 6;
      setv(-50 + n * 9, 7 * n);
      @(negedge clk);
      if (pp && fc == 2'd1 && fifo_count == 2'd1) ev++;
      pp = out_valid && out_ready;
      fc = fifo_count;
      if (in_valid && in_ready) n++;
    end
    checks++;
    if (ev < 3 || n != 6 || sb.size() != 0) begin
      failures++;
      $display("FAIL pop_capture: got same-edge events %0d sent %0d pending %0d want >=3 6 0", ev, n, sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int n = 0;
    for (int c = 0; c < 30 && !(fifo_count == 2'd1 && in_flight == 3'd1); c++) begin
      @(posedge clk); #1;
      out_ready = 0;
      in_valid = n < 2;
      setv(300 + n, 301 + n);
      @(negedge clk);
      if (in_valid && in_ready) n++;
    end
    checks++;
    if (fifo_count !== 2'd1 || in_flight !== 3'd1) begin
      failures++;
      $display("FAIL midop_setup: got count %0d in_flight %0d want 1 1", fifo_count, in_flight);
    end
    #1;
    reset = 1;
    in_valid = 0;
    sb.delete();
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, in_flight, fifo_count, overflow_err} !== 8'b0 ||
        {out_data[0], out_data[1], dp_in[0], dp_in[1]} !== '0) begin
      failures++;
      $display("FAIL midop_reset: got flags %b data %0d %0d dp_in %0d %0d want all 0",
               {in_ready, out_valid, in_flight, fifo_count, overflow_err}, out_data[0], out_data[1], dp_in[0], dp_in[1]);
    end
    @(posedge clk); #1;
    reset = 0;
    out_ready = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL midop_stale: cycle %0d out_valid %b in_ready %b want 0 1", c, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_overflow();
    int n = 0;
    for (int c = 0; c < 30 && fifo_count != 2'd2; c++) begin
      @(posedge clk); #1;
      out_ready = 0;
      in_valid = n < 2;
      setv(-1000 + n, 1000 - n);
      @(negedge clk);
      if (in_valid && in_ready) n++;
    end
    checks++;
    if (fifo_count !== 2'd2 || overflow_err !== 1'b0) begin
      failures++;
      $display("FAIL ovf_setup: got count %0d overflow %b want 2 0", fifo_count, overflow_err);
    end
    @(posedge clk); #1;
    in_valid = 0;
    force dut.tag = 4'b1000;
    @(posedge clk); #1;
    release dut.tag;
    @(negedge clk);
    checks++;
    if (overflow_err !== 1'b1 || fifo_count !== 2'd2 || {out_data[0], out_data[1]} !== {-17'sd999, 17'sd1001}) begin
      failures++;
      $display("FAIL ovf_set: got overflow %b count %0d head %0d,%0d want 1 2 -999,1001",
               overflow_err, fifo_count, out_data[0], out_data[1]);
    end
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1;
    for (int c = 0; c < 20 && sb.size() != 0; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (overflow_err !== 1'b1 || sb.size() != 0 || fifo_count !== 2'd0) begin
      failures++;
      $display("FAIL ovf_sticky: got overflow %b pending %0d count %0d want 1 0 0", overflow_err, sb.size(), fifo_count);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_pop_capture();
    test_reset_midop();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
